mux_escalonador_rr: RTL and testbench

- Round-robin scheduler that shares the 8:1 byte multiplexer between eight requesters (channels C1..C8).
- Picks one requesting channel and drives the mux selector, then holds it stable for one capture cycle.
- Registers the mux output and presents it downstream on a valid/ready handshake.
- Sits between the requesting channels and the mux select input on one side, and the byte consumer on the other.

---
 rtl/mux_escalonador_rr.sv | 106 ++++++++++
 tb/tb_mux_escalonador_rr.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_escalonador_rr.sv
// rtl/mux_escalonador_rr.sv - round-robin scheduler sharing an 8:1 byte mux between eight channels
module mux_escalonador_rr #(
    parameter int N_CANAIS = 8,
    parameter int LARGURA  = 8,
    parameter int SEL_W    = 3,
    parameter int CONT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CANAIS-1:0] req,
    output logic [N_CANAIS-1:0] gnt,
    output logic [SEL_W-1:0]    seletor,
    input  logic [LARGURA-1:0]  mux_saida,
    output logic [LARGURA-1:0]  dado_out,
    output logic                dado_valid,
    input  logic                dado_ready,
    output logic [SEL_W-1:0]    canal_out,
    output logic [CONT_W-1:0]   cont_transf
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CAPTURA = 2'd1,
        ENVIA   = 2'd2
    } estado_t;

    estado_t               estado_q;
    logic [SEL_W-1:0]      ptr_q;
    logic [N_CANAIS-1:0]   gnt_q;
    logic [SEL_W-1:0]      sel_q;
    logic [LARGURA-1:0]    dado_q;
    logic                  valid_q;
    logic [SEL_W-1:0]      canal_q;
    logic [CONT_W-1:0]     cont_q;

    logic                  win_found;
    logic [SEL_W-1:0]      win_idx;
    logic [SEL_W-1:0]      cand;
    logic [SEL_W-1:0]      ptr_prox;

    // Scan from farthest to nearest offset so the channel closest to ptr_q wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = N_CANAIS - 1; i >= 0; i--) begin
            cand = SEL_W'((int'(ptr_q) + i) % N_CANAIS);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign ptr_prox = SEL_W'((int'(sel_q) + 1) % N_CANAIS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            ptr_q    <= '0;
            gnt_q    <= '0;
            sel_q    <= '0;
            dado_q   <= '0;
            valid_q  <= 1'b0;
            canal_q  <= '0;
            cont_q   <= '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (win_found) begin
                        sel_q    <= win_idx;
                        gnt_q    <= {{(N_CANAIS-1){1'b0}}, 1'b1} << win_idx;
                        estado_q <= CAPTURA;
                    end
                end
                CAPTURA: begin
                    dado_q   <= mux_saida;
                    canal_q  <= sel_q;
                    valid_q  <= 1'b1;
                    estado_q <= ENVIA;
                end
                ENVIA: begin
                    // Last-served channel drops to lowest priority after the handshake.
                    if (dado_ready) begin
                        valid_q  <= 1'b0;
                        gnt_q    <= '0;
                        ptr_q    <= ptr_prox;
                        cont_q   <= cont_q + 1'b1;
                        estado_q <= OCIOSO;
                    end
                end
                default: begin
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign seletor     = sel_q;
    assign dado_out    = dado_q;
    assign dado_valid  = valid_q;
    assign canal_out   = canal_q;
    assign cont_transf = cont_q;

endmodule

// File: tb/tb_mux_escalonador_rr.sv
// tb/tb_mux_escalonador_rr.sv - self-checking bench for mux_escalonador_rr
module tb_mux_escalonador_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  req;
    logic [7:0]  gnt;
    logic [2:0]  seletor;
    logic [7:0]  mux_saida;
    logic [7:0]  dado_out;
    logic        dado_valid;
    logic        dado_ready;
    logic [2:0]  canal_out;
    logic [15:0] cont_transf;
    logic [7:0]  mux_in [8];

    always #5 clk = ~clk;

    assign mux_saida = mux_in[seletor];

    mux_escalonador_rr #(
        .N_CANAIS(8), .LARGURA(8), .SEL_W(3), .CONT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .seletor(seletor),
        .mux_saida(mux_saida), .dado_out(dado_out), .dado_valid(dado_valid),
        .dado_ready(dado_ready), .canal_out(canal_out), .cont_transf(cont_transf)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    int         m_fase;
    int         m_ptr;
    int         m_k;
    int         m_cnt;
    logic [7:0] m_gnt;
    logic [7:0] m_dout;
    logic       m_valid;
    int         m_canal;
    int         served[$];
    int         served_dat[$];

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int vencedor(logic [7:0] r, int p);
        for (int i = 0; i < 8; i++)
            if (r[(p + i) % 8]) return (p + i) % 8;
        return -1;
    endfunction

    // Transaction-level model: one grant, one capture, then wait for the handshake.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_fase = 0; m_ptr = 0; m_k = 0; m_cnt = 0;
            m_gnt = '0; m_dout = '0; m_valid = 1'b0; m_canal = 0;
        end else begin
            case (m_fase)
                0: if (req != 0) begin
                    m_k   = vencedor(req, m_ptr);
                    m_gnt = 8'(1 << m_k);
                    m_fase = 1;
                end
                1: begin
                    m_dout  = mux_in[m_k];
                    m_canal = m_k;
                    m_valid = 1'b1;
                    m_fase  = 2;
                end
                default: if (dado_ready) begin
                    m_valid = 1'b0;
                    m_gnt   = '0;
                    m_ptr   = (m_k + 1) % 8;
                    m_cnt   = (m_cnt + 1) % 65536;
                    served.push_back(m_k);
                    served_dat.push_back(int'(m_dout));
                    m_fase  = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt", gnt, m_gnt);
            check("dado_valid", dado_valid, m_valid);
            check("cont_transf", cont_transf, m_cnt);
            check("gnt_onehot0", $onehot0(gnt), 1);
            if (m_gnt != 0) check("seletor", seletor, m_k);
            if (m_valid) begin
                check("dado_out", dado_out, m_dout);
                check("canal_out", canal_out, m_canal);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_served(int n);
        int t = 0;
        while (served.size() < n && t < 300) begin
            tick();
            t++;
        end
        check("wait_served_timeout", served.size() >= n, 1);
    endtask

    task automatic wait_valid;
        int t = 0;
        while (!m_valid && t < 20) begin
            tick();
            t++;
        end
        check("wait_valid_timeout", m_valid, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0;
        dado_ready = 1'b1;
        for (int i = 0; i < 8; i++) mux_in[i] = 8'(i);
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_gnt", gnt, 0);
        check("rst_seletor", seletor, 0);
        check("rst_dado_out", dado_out, 0);
        check("rst_valid", dado_valid, 0);
        check("rst_canal", canal_out, 0);
        check("rst_cont", cont_transf, 0);

        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_gnt", gnt, 0);
        check("idle_seletor", seletor, 0);
        check("idle_valid", dado_valid, 0);
        check("idle_cont", cont_transf, 0);

        // Single requester C3
        served.delete(); served_dat.delete();
        req = 8'h04;
        tick();
        check("single_gnt", gnt, 8'h04);
        check("single_seletor", seletor, 2);
        tick();
        check("single_dado", dado_out, 8'h02);
        check("single_canal", canal_out, 2);
        check("single_valid", dado_valid, 1);
        req = '0;
        tick();
        check("single_cont", cont_transf, 1);
        check("single_valid_low", dado_valid, 0);
        check("single_gnt_low", gnt, 0);
        if (served.size() > 0) check("model_single", served[0], 2);

        // Round-robin from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        served.delete(); served_dat.delete();
        req = 8'hFF;
        wait_served(9);
        req = '0;
        for (int i = 0; i < 9; i++) begin
            if (served.size() > i) begin
                check("rr_canal", served[i], i % 8);
                check("rr_dado", served_dat[i], i % 8);
            end
        end
        check("rr_cont", cont_transf, 9);

        // Pointer wrap 7 -> 0
        served.delete(); served_dat.delete();
        req = 8'h40;
        wait_served(1);
        req = 8'h81;
        wait_served(3);
        req = '0;
        if (served.size() >= 3) begin
            check("wrap_first", served[0], 6);
            check("wrap_c8_first", served[1], 7);
            check("wrap_c1_after", served[2], 0);
        end

        // Backpressure on channel C5
        dado_ready = 1'b0;
        req = 8'h10;
        wait_valid();
        req = '0;
        check("bp_cont_before", cont_transf, 12);
        repeat (10) begin
            for (int i = 0; i < 8; i++) mux_in[i] = 8'($urandom);
            tick();
            check("bp_dado", dado_out, 8'h04);
            check("bp_canal", canal_out, 4);
            check("bp_gnt", gnt, 8'h10);
            check("bp_valid", dado_valid, 1);
            check("bp_cont", cont_transf, 12);
        end
        dado_ready = 1'b1;
        tick();
        check("bp_cont_after", cont_transf, 13);
        check("bp_valid_after", dado_valid, 0);
        for (int i = 0; i < 8; i++) mux_in[i] = 8'(i);

        // Reset during ENVIA
        dado_ready = 1'b0;
        req = 8'h08;
        wait_valid();
        rst_n = 1'b0;
        tick();
        check("rmid_gnt", gnt, 0);
        check("rmid_valid", dado_valid, 0);
        check("rmid_cont", cont_transf, 0);
        rst_n = 1'b1;
        dado_ready = 1'b1;
        req = 8'hFF;
        served.delete(); served_dat.delete();
        wait_served(1);
        req = '0;
        if (served.size() > 0) check("rmid_first", served[0], 0);

        // Randomized traffic with occasional resets
        repeat (3000) begin
            req = 8'($urandom);
            if ($urandom_range(0, 3) == 0) req = '0;
            dado_ready = ($urandom_range(0, 3) != 0);
            mux_in[$urandom_range(0, 7)] = 8'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1'b1;
        req = '0;
        dado_ready = 1'b1;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
